// File: rtl/prog_load_pkg.sv
// Shared types for the program load/run controller: FSM state encoding and
// host write-record target codes.
package prog_load_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_RST_PULSE = 3'd2,
    ST_RUN       = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  localparam logic [1:0] TGT_IMEM = 2'd0;
  localparam logic [1:0] TGT_REG  = 2'd1;
  localparam logic [1:0] TGT_DMEM = 2'd2;
  localparam logic [1:0] TGT_RSVD = 2'd3;

endpackage

// File: rtl/prog_load_ctrl_run_counter.sv
// Run budget tracker: loadable down-counter with a last flag, and a
// saturating up-counter reporting cycles executed.
module run_counter #(
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CYC_W-1:0] load_val,
  input  logic             en,
  output logic             last,
  output logic [CYC_W-1:0] cyc_count
);

  localparam logic [CYC_W-1:0] ONE = CYC_W'(1);

  logic [CYC_W-1:0] rem_q, rem_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;

  always_comb begin
    rem_d = rem_q;
    cnt_d = cnt_q;
    if (load) begin
      rem_d = load_val;
      cnt_d = '0;
    end else if (en) begin
      rem_d = rem_q - ONE;
      if (cnt_q != '1) cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  assign last      = (rem_q == ONE);
  assign cyc_count = cnt_q;

endmodule

// File: rtl/prog_load_ctrl.sv
// Load/run sequencer for pipeline_processor: streams host records into the
// core memories, then runs it for a budget. Optional PLC_SINGLE_STEP_EN adds step gating.
module prog_load_ctrl
  import prog_load_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RF_AW   = 3,
  parameter int IMEM_AW = 4,
  parameter int DMEM_AW = 4,
  parameter int CYC_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [1:0]         s_target,
  input  logic [IMEM_AW-1:0] s_addr,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               go,
  input  logic [CYC_W-1:0]   run_cycles,
  input  logic               abort,
`ifdef PLC_SINGLE_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  output logic               cpu_rst,
  output logic               cpu_en,
  output logic               imem_we,
  output logic               dmem_we,
  output logic               rf_we,
  output logic [IMEM_AW-1:0] wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CYC_W-1:0]   cyc_count
);

  localparam logic [IMEM_AW-1:0] RF_MASK   = IMEM_AW'((1 << RF_AW) - 1);
  localparam logic [IMEM_AW-1:0] DMEM_MASK = IMEM_AW'((1 << DMEM_AW) - 1);

  state_e state_q, state_d;
  logic   imem_we_q, imem_we_d, dmem_we_q, dmem_we_d, rf_we_q, rf_we_d;
  logic   err_q, err_d;
  logic [IMEM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;

  logic accept, go_acc, run_en, cnt_load, cnt_en, cnt_last;

`ifdef PLC_SINGLE_STEP_EN
  assign run_en = !step_mode || step;
`else
  assign run_en = 1'b1;
`endif

  assign s_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_DONE);
  assign accept  = s_valid && s_ready;
  assign go_acc  = go && s_ready;

  // Next-state; go overrides the record-driven move into LOAD.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: if (accept) state_d = ST_LOAD;
      ST_RST_PULSE:     state_d = ST_RUN;
      ST_RUN: begin
        if (abort) state_d = ST_DONE;
        else if (run_en) begin
          cnt_en = 1'b1;
          if (cnt_last) state_d = ST_DONE;
        end
      end
      default: ;
    endcase
    if (go_acc) begin
      cnt_load = 1'b1;
      state_d  = (run_cycles == '0) ? ST_DONE : ST_RST_PULSE;
    end
  end

  // Write path: strobe lands the cycle after acceptance.
  always_comb begin
    imem_we_d = accept && (s_target == TGT_IMEM);
    rf_we_d   = accept && (s_target == TGT_REG);
    dmem_we_d = accept && (s_target == TGT_DMEM);
    err_d     = err_q || (accept && (s_target == TGT_RSVD));
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (accept) begin
      wr_data_d = s_data;
      case (s_target)
        TGT_REG:  wr_addr_d = s_addr & RF_MASK;
        TGT_DMEM: wr_addr_d = s_addr & DMEM_MASK;
        default:  wr_addr_d = s_addr;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      imem_we_q <= 1'b0;
      rf_we_q   <= 1'b0;
      dmem_we_q <= 1'b0;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      imem_we_q <= imem_we_d;
      rf_we_q   <= rf_we_d;
      dmem_we_q <= dmem_we_d;
      err_q     <= err_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  run_counter #(.CYC_W(CYC_W)) u_run_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .load_val  (run_cycles),
    .en        (cnt_en),
    .last      (cnt_last),
    .cyc_count (cyc_count)
  );

  // Core is held in reset while loading; DONE leaves it frozen but out of reset.
  assign cpu_rst = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_RST_PULSE);
  assign cpu_en  = (state_q == ST_RUN) && run_en;
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done    = (state_q == ST_DONE);
  assign err     = err_q;
  assign imem_we = imem_we_q;
  assign rf_we   = rf_we_q;
  assign dmem_we = dmem_we_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
